data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 8-bit × 256-word data memory. Requester 0 is the core load/store path and requester 1 is the program/data loader. Each has a req/gnt handshake and gets a registered read-data return. The block owns the memory's address, write-data and write-enable pins and samples its combinational read data. An optional power-up sequencer fills the whole memory with a constant before any requester is granted.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width; depth = 2^ADDR_W.
- `DATA_W`, 8: memory word width.
- `CLEAR_VALUE`, 8'h00: fill value written by the clear sequencer.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request from requester 0 / 1.
- `write0` / `write1`  in  1  1 = store, 0 = load; qualified by req.
- `addr0` / `addr1`  in  ADDR_W  access address.
- `wdata0` / `wdata1`  in  DATA_W  store data.
- `gnt0` / `gnt1`  out  1  grant; combinational, at most one high.
- `rdata0` / `rdata1`  out  DATA_W  registered load data.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse, rdata valid.
- `memAddr`  out  ADDR_W  to memory address.
- `memDataIn`  out  DATA_W  to memory write data.
- `memWriteEnable`  out  1  to memory write enable.
- `memDataOut`  in  DATA_W  memory combinational read data.
- `ready`  out  1  high once clear is done (or immediately if clear is compiled out).

## Operation
- States: CLEAR, SERVE. Reset enters CLEAR if `MEM_CLEAR_EN` is defined, otherwise SERVE.
- **CLEAR**
  - `memAddr` = clearCount, `memDataIn` = CLEAR_VALUE, `memWriteEnable` = 1.
  - clearCount increments each cycle.
  - After the write at address 2^ADDR_W−1, the state goes to SERVE.
  - `gnt0`/`gnt1` = 0 and `ready` = 0 throughout.
- **SERVE**
  - `ready` = 1.
  - Grant logic:
    - Only one req high: that requester is granted in the same cycle.
    - Both high: grant goes to the requester not named by lastGrant.
    - Neither high: no grant, `memWriteEnable` = 0, `memAddr` = addr0.
- **Transfer** happens on the rising edge where reqN && gntN.
  - `memAddr`, `memDataIn` and `memWriteEnable` (= writeN) are driven from the granted requester's inputs that cycle.
  - lastGrant ← N.
  - On a load, rdataN ← `memDataOut` and rvalidN = 1 for the next cycle only.
  - A store produces no rvalid. rdataN holds its value until the next load by N.
- **Requester rules**
  - reqN, writeN, addrN and wdataN are held stable until the transfer edge.
  - reqN may be held high for back-to-back accesses; with both requesting continuously, grants alternate 0,1,0,1.
  - Dropping reqN before a grant is legal; no access occurs.
- Simultaneous rvalid0 and rvalid1 is impossible, since there is at most one transfer per cycle.

## Timing
- Reset values:
  - `gnt0` = `gnt1` = 0
  - `rdata0` = `rdata1` = 0
  - `rvalid0` = `rvalid1` = 0
  - `memWriteEnable` = 0
  - `ready` = 0 with clear enabled, 1 without
  - lastGrant = 1, so requester 0 wins the first tie
  - clearCount = 0
- Grant latency: 0 cycles (combinational from req in SERVE).
- Load latency: rdata/rvalid valid 1 cycle after the transfer edge.
- Store: the memory is written at the transfer edge, and a load to the same address in the next cycle returns the new data.
- Clear takes exactly 2^ADDR_W cycles (256 at defaults). `ready` rises on the edge after the last clear write.
- Reset asserted mid-clear or mid-access:
  - All outputs return to their reset values immediately.
  - Clear restarts from address 0 after release.
  - In-flight rvalid is lost.
- clearCount is ADDR_W+1 bits wide, and its wrap is the termination condition. Addresses never wrap silently.

## Configuration
- `MEM_CLEAR_EN` defined: CLEAR state, clear counter and `ready` gating are compiled in, and the memory is filled with CLEAR_VALUE after every reset.
- `MEM_CLEAR_EN` undefined: there is no CLEAR state, `ready` = 1 from reset release, and memory contents are undefined until written.
- All other behaviour is identical in both builds.

## Test plan
- Reset with `MEM_CLEAR_EN`: hold `req0` high from reset release.
  - `gnt0` stays 0 for 256 cycles, then `ready` = 1 and `gnt0` = 1.
  - A load of 8'hA5 returns 8'h00.
- Single store/load: requester 1 stores 8'h3C to 8'h10, then loads 8'h10.
  - `gnt1` is high in both request cycles.
  - `rvalid1` pulses once, with `rdata1` = 8'h3C.
- Contention: both requesters assert loads continuously (addr0 = 8'h01, addr1 = 8'h02).
  - Grants go 0,1,0,1.
  - `rvalid0`/`rvalid1` alternate, each pulse one cycle wide.
- Same-cycle hazard: requester 0 stores 8'h77 to 8'h20; requester 1 loads 8'h20 in the following cycle.
  - `rdata1` = 8'h77.
- Reset mid-clear: assert `resetN` low at clear address 8'h80, then release.
  - Outputs are at reset values while reset is low.
  - Clear restarts at address 0 and takes a full 256 cycles.
- Build without `MEM_CLEAR_EN`: `req0` load in the first cycle after reset.
  - `gnt0` = 1 immediately.
  - `rvalid0` pulses in the next cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester round-robin arbiter and sequencer for a single-port data memory.
// Latency: grant is combinational from req; load data and rvalid are registered, one cycle after the transfer edge.
// Backpressure: a requester holds req/write/addr/wdata until it is granted; no grants while the clear sequencer runs.
// Build option: define MEM_CLEAR_EN to compile in the power-up fill of every word with CLEAR_VALUE.
module data_mem_arbiter #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memWriteEnable,
    input  logic [DATA_W-1:0] memDataOut,
    output logic              ready
);

    // Arbitration is allowed only when the clear sequencer is finished and reset is released.
    logic              w_serve;
    logic              w_arb_en;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;

    // Index of the requester that made the most recent transfer; the other one wins a tie.
    logic              r_last_gnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;

`ifdef MEM_CLEAR_EN
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_SERVE = 1'b1;

    logic [0:0]        r_state;
    // One bit wider than the address: the carry into the top bit marks the last write.
    logic [ADDR_W:0]   r_clear_cnt;
    logic [ADDR_W:0]   w_clear_cnt_nxt;
    logic [ADDR_W-1:0] w_clear_addr;

    assign w_clear_cnt_nxt = r_clear_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_clear_addr    = r_clear_cnt[ADDR_W-1:0];

    // Clear sequencer: write every address once after reset, then hand the memory to the arbiter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_CLEAR;
            r_clear_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clear_cnt <= w_clear_cnt_nxt;
            if (w_clear_cnt_nxt[ADDR_W]) begin
                r_state <= S_SERVE;
            end
        end
    end

    assign w_serve = (r_state == S_SERVE);
`else
    assign w_serve = 1'b1;
`endif

    // Round-robin grant; reset gates it so the outputs sit at their reset values while resetN is low.
    assign w_arb_en = resetN & w_serve;
    assign w_gnt0   = w_arb_en & req0 & (~req1 | r_last_gnt);
    assign w_gnt1   = w_arb_en & req1 & (~req0 | ~r_last_gnt);

    // Memory pin mux: clear sequencer, granted requester, or idle (address follows requester 0).
    always_comb begin
        w_mem_addr  = addr0;
        w_mem_wdata = CLEAR_VALUE;
        w_mem_we    = 1'b0;
        if (w_gnt1) begin
            w_mem_addr  = addr1;
            w_mem_wdata = wdata1;
            w_mem_we    = write1;
        end else if (w_gnt0) begin
            w_mem_addr  = addr0;
            w_mem_wdata = wdata0;
            w_mem_we    = write0;
        end
`ifdef MEM_CLEAR_EN
        if (!w_serve) begin
            w_mem_addr  = w_clear_addr;
            w_mem_wdata = CLEAR_VALUE;
            w_mem_we    = resetN;
        end
`endif
    end

    // Remember who transferred last so a tie goes to the other requester.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end
    end

    // Requester 0 load return: capture memory read data and pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rdata0  <= '0;
            r_rvalid0 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~write0;
            if (w_gnt0 && !write0) begin
                r_rdata0 <= memDataOut;
            end
        end
    end

    // Requester 1 load return: capture memory read data and pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rdata1  <= '0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid1 <= w_gnt1 & ~write1;
            if (w_gnt1 && !write1) begin
                r_rdata1 <= memDataOut;
            end
        end
    end

    assign gnt0           = w_gnt0;
    assign gnt1           = w_gnt1;
    assign rdata0         = r_rdata0;
    assign rdata1         = r_rdata1;
    assign rvalid0        = r_rvalid0;
    assign rvalid1        = r_rvalid1;
    assign memAddr        = w_mem_addr;
    assign memDataIn      = w_mem_wdata;
    assign memWriteEnable = w_mem_we;
    assign ready          = w_serve;

endmodule
